// File: rtl/traf_pkg.sv
// Shared encodings for the traffic-light phase controller: one-hot timer phases,
// internal FSM states, lamp codes and the timer reload values.
package traf_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned LOAD_W  = 8;

  localparam logic [STATE_W-1:0] ST0     = 4'b0001;
  localparam logic [STATE_W-1:0] ST1     = 4'b0010;
  localparam logic [STATE_W-1:0] ST2     = 4'b0100;
  localparam logic [STATE_W-1:0] ST3     = 4'b1000;
  localparam logic [STATE_W-1:0] ST_NONE = 4'b0000;

  typedef enum logic [2:0] {
    S_NSG    = 3'd0,
    S_NSY    = 3'd1,
    S_EWG    = 3'd2,
    S_EWY    = 3'd3,
    S_FLASH  = 3'd4,
    S_RESYNC = 3'd5
  } phase_e;

  // Lamp codes are {R,Y,G}
  localparam logic [LAMP_W-1:0] RED = 3'b100;
  localparam logic [LAMP_W-1:0] YEL = 3'b010;
  localparam logic [LAMP_W-1:0] GRN = 3'b001;
  localparam logic [LAMP_W-1:0] OFF = 3'b000;

  localparam logic [LOAD_W-1:0] green_NS  = 8'h36;
  localparam logic [LOAD_W-1:0] yellow_NS = 8'h04;
  localparam logic [LOAD_W-1:0] red_NS    = 8'h3b;
  localparam logic [LOAD_W-1:0] green_EW  = 8'h36;
  localparam logic [LOAD_W-1:0] yellow_EW = 8'h04;
  localparam logic [LOAD_W-1:0] red_EW    = 8'h3b;

  // Value a timer takes when loaded while State shows st: the duration of the phase that follows st.
  function automatic logic [LOAD_W-1:0] load_value(input logic is_ns, input logic [STATE_W-1:0] st);
    logic [LOAD_W-1:0] v;
    v = is_ns ? green_NS : red_EW;
    case (st)
      ST0:     v = is_ns ? yellow_NS : red_EW;
      ST1:     v = is_ns ? red_NS    : green_EW;
      ST2:     v = is_ns ? red_NS    : yellow_EW;
      ST3:     v = is_ns ? green_NS  : red_EW;
      default: v = is_ns ? green_NS  : red_EW;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traf_ctl_fsm_if.sv
// Controller <-> timer/lamp signal bundle; master is the phase controller side.
interface traf_ctl_fsm_if;
  import traf_pkg::*;

  logic                 Done_NS;
  logic                 Done_EW;
  logic                 Maint;
  logic [STATE_W-1:0]   State;
  logic                 Ld_NS;
  logic                 Ld_EW;
  logic                 En_NS;
  logic                 En_EW;
  logic [LAMP_W-1:0]    Light_NS;
  logic [LAMP_W-1:0]    Light_EW;

  modport master (
    input  Done_NS, Done_EW, Maint,
    output State, Ld_NS, Ld_EW, En_NS, En_EW, Light_NS, Light_EW
  );

  modport slave (
    output Done_NS, Done_EW, Maint,
    input  State, Ld_NS, Ld_EW, En_NS, En_EW, Light_NS, Light_EW
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: registered one-cycle Tick every TICK_DIV clocks,
// first Tick TICK_DIV cycles after Reset drops.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned TICK_W   = 32
) (
  input  logic Clk,
  input  logic Reset,
  output logic Tick
);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else if (cnt == TICK_W'(TICK_DIV - 1)) begin
      cnt  <= '0;
      Tick <= 1'b1;
    end else begin
      cnt  <= cnt + TICK_W'(1);
      Tick <= 1'b0;
    end
  end

endmodule

// File: rtl/traf_ctl_fsm.sv
// Traffic-light phase controller: sequences NS/EW phases from timer Done flags,
// drives timer Ld/En/State, and provides a maintenance flashing-yellow mode.
module traf_ctl_fsm
  import traf_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned TICK_W   = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  traf_ctl_fsm_if.master bus
);

  logic               tick;
  phase_e             state;
  logic               blink;
  logic               normal_c;
  logic [STATE_W-1:0] st_oh_c;
  logic [LAMP_W-1:0]  lamp_ns_c;
  logic [LAMP_W-1:0]  lamp_ew_c;

  tick_gen #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) u_tick_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .Tick  (tick)
  );

  // Phase register; Maint pre-empts any Done, blink only runs while flashing
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_NSG;
      blink <= 1'b0;
    end else begin
      blink <= 1'b0;
      case (state)
        S_NSG:    if (bus.Maint) state <= S_FLASH; else if (bus.Done_NS) state <= S_NSY;
        S_NSY:    if (bus.Maint) state <= S_FLASH; else if (bus.Done_NS) state <= S_EWG;
        S_EWG:    if (bus.Maint) state <= S_FLASH; else if (bus.Done_EW) state <= S_EWY;
        S_EWY:    if (bus.Maint) state <= S_FLASH; else if (bus.Done_EW) state <= S_NSG;
        S_FLASH: begin
          if (!bus.Maint) state <= S_RESYNC;
          blink <= tick ? ~blink : blink;
        end
        S_RESYNC: state <= bus.Maint ? S_FLASH : S_NSG;
        default:  state <= S_NSG;
      endcase
    end
  end

  // Phase/lamp decode from registered state only
  always_comb begin
    normal_c  = 1'b0;
    st_oh_c   = ST0;
    lamp_ns_c = GRN;
    lamp_ew_c = RED;
    case (state)
      S_NSG:    begin normal_c = 1'b1; st_oh_c = ST0; lamp_ns_c = GRN; lamp_ew_c = RED; end
      S_NSY:    begin normal_c = 1'b1; st_oh_c = ST1; lamp_ns_c = YEL; lamp_ew_c = RED; end
      S_EWG:    begin normal_c = 1'b1; st_oh_c = ST2; lamp_ns_c = RED; lamp_ew_c = GRN; end
      S_EWY:    begin normal_c = 1'b1; st_oh_c = ST3; lamp_ns_c = RED; lamp_ew_c = YEL; end
      S_FLASH:  begin
        st_oh_c   = ST_NONE;
        lamp_ns_c = blink ? YEL : OFF;
        lamp_ew_c = blink ? YEL : OFF;
      end
      S_RESYNC: begin st_oh_c = ST3; lamp_ns_c = RED; lamp_ew_c = RED; end
      default:  begin st_oh_c = ST0; lamp_ns_c = GRN; lamp_ew_c = RED; end
    endcase
  end

  assign bus.State    = st_oh_c;
  assign bus.Light_NS = lamp_ns_c;
  assign bus.Light_EW = lamp_ew_c;
  assign bus.En_NS    = normal_c & tick;
  assign bus.En_EW    = normal_c & tick;
  // A timer reloads whenever it expires, even in a phase that ignores it, unless Maint cuts in
  assign bus.Ld_NS    = (normal_c & ~bus.Maint & bus.Done_NS) | (state == S_RESYNC);
  assign bus.Ld_EW    = (normal_c & ~bus.Maint & bus.Done_EW) | (state == S_RESYNC);

endmodule

// File: tb/tb_traf_ctl_fsm.sv
// Scoreboard bench for traf_ctl_fsm with TICK_DIV=4: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_traf_ctl_fsm;
  import traf_pkg::*;

  localparam int unsigned TDIV = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  traf_ctl_fsm_if ifc ();

  traf_ctl_fsm #(.TICK_DIV(TDIV), .TICK_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  // Stub Done sources or a countdown-timer model for both roads
  logic       use_model = 1'b0;
  logic       stub_ns = 1'b0, stub_ew = 1'b0, maint = 1'b0;
  logic [7:0] q_ns, q_ew;
  logic       m_done_ns, m_done_ew;

  assign m_done_ns   = (q_ns == 8'd0) & ifc.En_NS;
  assign m_done_ew   = (q_ew == 8'd0) & ifc.En_EW;
  assign ifc.Done_NS = use_model ? m_done_ns : stub_ns;
  assign ifc.Done_EW = use_model ? m_done_ew : stub_ew;
  assign ifc.Maint   = maint;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_ns <= green_NS;
      q_ew <= red_EW;
    end else begin
      if (ifc.Ld_NS)      q_ns <= load_value(1'b1, ifc.State);
      else if (ifc.En_NS) q_ns <= q_ns - 8'd1;
      if (ifc.Ld_EW)      q_ew <= load_value(1'b0, ifc.State);
      else if (ifc.En_EW) q_ew <= q_ew - 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [13:0] exp;
    bit          chk_q;
    logic [7:0]  q;
  } chk_t;

  chk_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  chk_t        mc;
  logic [13:0] got;

  // Monitor: compare every queued expectation due in this cycle
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mc  = sb.pop_front();
      got = {ifc.State, ifc.Ld_NS, ifc.Ld_EW, ifc.En_NS, ifc.En_EW, ifc.Light_NS, ifc.Light_EW};
      n_checks++;
      if (mc.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (monitor at %0d)", mc.name, mc.cyc, cyc);
      end else if (got !== mc.exp || (mc.chk_q && q_ns !== mc.q)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got {St,LdN,LdE,EnN,EnE,LN,LE}=%b_%b%b%b%b_%b_%b q_ns=%h, required %b_%b%b%b%b_%b_%b q_ns=%h",
                 mc.name, cyc, got[13:10], got[9], got[8], got[7], got[6], got[5:3], got[2:0], q_ns,
                 mc.exp[13:10], mc.exp[9], mc.exp[8], mc.exp[7], mc.exp[6], mc.exp[5:3], mc.exp[2:0],
                 mc.chk_q ? mc.q : q_ns);
      end
    end
  end

  int rel = 0;

  function automatic bit tk();
    return (rel % TDIV == 0) && (rel != 0);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
    rel++;
  endtask

  task automatic push(input string nm, input logic [3:0] st, input logic ln, input logic le,
                      input logic en, input logic [2:0] lns, input logic [2:0] lew,
                      input bit cq = 1'b0, input logic [7:0] q = 8'h00);
    chk_t c;
    c.cyc   = cyc;
    c.name  = nm;
    c.exp   = {st, ln, le, en, en, lns, lew};
    c.chk_q = cq;
    c.q     = q;
    sb.push_back(c);
  endtask

  task automatic reset_dut(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
    rel = 0;
  endtask

  logic [3:0] ph_st  [4] = '{ST0, ST1, ST2, ST3};
  logic [2:0] ph_lns [4] = '{GRN, YEL, RED, RED};
  logic [2:0] ph_lew [4] = '{RED, RED, GRN, YEL};
  bit         ph_ns  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check_idle(input int p, input string nm);
    push(nm, ph_st[p], 1'b0, 1'b0, tk(), ph_lns[p], ph_lew[p]);
  endtask

  task automatic run_to_tick(input int p);
    while (!tk()) begin
      check_idle(p, "phase_hold");
      step();
    end
  endtask

  // Raise the consuming Done on a tick, expect Ld that cycle and the next phase after
  task automatic advance_phase(input int p);
    run_to_tick(p);
    stub_ns = ph_ns[p];
    stub_ew = !ph_ns[p];
    push("done_ld", ph_st[p], ph_ns[p], !ph_ns[p], 1'b1, ph_lns[p], ph_lew[p]);
    step();
    stub_ns = 1'b0;
    stub_ew = 1'b0;
    check_idle((p + 1) % 4, "phase_next");
  endtask

  logic blink_e;

  initial begin
    // 1: reset state and tick cadence; stray Done_EW reloads EW but is not consumed
    reset_dut(3);
    push("reset", ST0, 1'b0, 1'b0, 1'b0, GRN, RED);
    for (int i = 1; i < 12; i++) begin
      step();
      stub_ew = (rel == 6);
      if (rel == 6) push("ignored_done_ew", ST0, 1'b0, 1'b1, 1'b0, GRN, RED);
      else          check_idle(0, "tick_cadence");
    end
    step();
    stub_ew = 1'b0;

    // 2: full stubbed phase walk back to NSG
    for (int p = 0; p < 4; p++) advance_phase(p);

    // 6a: reset while in S_EWY restarts phase and prescaler
    for (int p = 0; p < 3; p++) advance_phase(p);
    step();
    reset_dut(1);
    push("reset_from_ewy", ST0, 1'b0, 1'b0, 1'b0, GRN, RED);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_idle(0, "prescaler_restart");
    end

    // 3: integration with the timer model
    use_model = 1'b1;
    reset_dut(3);
    push("integ_reset", ST0, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b1, green_NS);
    for (int i = 1; i <= 481; i++) begin
      step();
      case (rel)
        220: push("integ_nsg_end", ST0, 1'b1, 1'b0, 1'b1, GRN, RED);
        221: push("integ_nsy",     ST1, 1'b0, 1'b0, 1'b0, YEL, RED);
        240: push("integ_nsy_end", ST1, 1'b1, 1'b1, 1'b1, YEL, RED);
        241: push("integ_ewg",     ST2, 1'b0, 1'b0, 1'b0, RED, GRN);
        460: push("integ_ewg_end", ST2, 1'b0, 1'b1, 1'b1, RED, GRN);
        461: push("integ_ewy",     ST3, 1'b0, 1'b0, 1'b0, RED, YEL);
        480: push("integ_ewy_end", ST3, 1'b1, 1'b1, 1'b1, RED, YEL);
        481: push("integ_wrap",    ST0, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b1, green_NS);
        default: ;
      endcase
    end
    use_model = 1'b0;

    // 4: Maint beats a simultaneous Done_NS, then flash
    run_to_tick(0);
    stub_ns = 1'b1;
    maint   = 1'b1;
    push("maint_priority", ST0, 1'b0, 1'b0, 1'b1, GRN, RED);
    step();
    blink_e = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stub_ns = (rel == 490);
      push("flash", ST_NONE, 1'b0, 1'b0, 1'b0, {1'b0, blink_e, 1'b0}, {1'b0, blink_e, 1'b0});
      if (tk()) blink_e = ~blink_e;
      step();
    end
    stub_ns = 1'b0;

    // 5: leaving flash passes through a single resync cycle
    maint = 1'b0;
    push("flash_exit", ST_NONE, 1'b0, 1'b0, 1'b0, {1'b0, blink_e, 1'b0}, {1'b0, blink_e, 1'b0});
    step();
    push("resync", ST3, 1'b1, 1'b1, 1'b0, RED, RED);
    step();
    push("resync_to_nsg", ST0, 1'b0, 1'b0, tk(), GRN, RED, 1'b1, green_NS);

    // 6b: reset asserted mid-flash
    maint = 1'b1;
    step();
    push("flash_reenter", ST_NONE, 1'b0, 1'b0, 1'b0, OFF, OFF);
    step();
    maint = 1'b0;
    reset_dut(2);
    push("reset_from_flash", ST0, 1'b0, 1'b0, 1'b0, GRN, RED);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_idle(0, "prescaler_restart2");
    end

    repeat (2) @(posedge Clk);
    #1;
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never compared", mc.name, mc.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/traf_ctl_fsm.md
Name: traf_ctl_fsm

Overview:
Phase controller for the two-road traffic-light design. It sits directly upstream of the NS and EW countdown timers and drives their Ld, En and State inputs. It consumes their Done flags to sequence the four light phases. It also owns the 1-tick prescaler and a maintenance flashing-yellow mode.

Parameters:
TICK_DIV, 50000000, Clk cycles per timer tick (1 s at 50 MHz); legal range 2..2^32-1
TICK_W, 32, width of prescaler counter; must satisfy 2^TICK_W > TICK_DIV

Ports:
Clk      in   1  clock; all state updates on posedge
Reset    in   1  synchronous, active-high reset
Done_NS  in   1  NS timer expired (Q_NS==0 and En_NS), combinational from timer
Done_EW  in   1  EW timer expired, same semantics
Maint    in   1  level; 1 = maintenance flash mode
State    out  4  one-hot phase to both timers: St0=0001, St1=0010, St2=0100, St3=1000
Ld_NS    out  1  load NS timer per State
Ld_EW    out  1  load EW timer per State
En_NS    out  1  NS timer decrement enable (tick pulse)
En_EW    out  1  EW timer decrement enable (tick pulse)
Light_NS out  3  {R,Y,G} NS lamps
Light_EW out  3  {R,Y,G} EW lamps

Behaviour:
- Prescaler: counter 0..TICK_DIV-1, wraps. Registered tick is 1 for exactly one cycle per wrap. The first tick occurs TICK_DIV cycles after Reset deasserts. The prescaler runs in all states.
- Internal states: S_NSG (State St0), S_NSY (St1), S_EWG (St2), S_EWY (St3), S_FLASH (State 0000), S_RESYNC (State St3).
- Reset: state S_NSG, prescaler 0, tick 0, blink 0.
  - All outputs: Ld_*=0, En_*=0, State=0001, Light_NS=001, Light_EW=100.
  - The timers self-load on the same Reset.
- En_NS = En_EW = tick in the four normal states; 0 in S_FLASH and S_RESYNC.
- Ld_NS = Done_NS in normal states; 1 in S_RESYNC; else 0. Ld_EW likewise with Done_EW.
- Ld and Done are combinational. Ld never feeds back into En, so there is no loop.
- Transitions on posedge, Maint=0:
  - S_NSG -> S_NSY when Done_NS
  - S_NSY -> S_EWG when Done_NS
  - S_EWG -> S_EWY when Done_EW
  - S_EWY -> S_NSG when Done_EW
  - A phase change and the corresponding timer load occur on the same edge.
- Lights:
  - S_NSG: NS=001, EW=100
  - S_NSY: NS=010, EW=100
  - S_EWG: NS=100, EW=001
  - S_EWY: NS=100, EW=010
  - S_FLASH: NS=EW={0,blink,0}
  - S_RESYNC: NS=100, EW=100
- Lights are decoded from registered state only, so they are glitch-free.
- Maint=1 in any state except S_FLASH -> next state S_FLASH. Maint has priority over a simultaneous Done; no Ld is issued in that cycle.
- S_FLASH:
  - blink toggles on each tick; blink is cleared on entry.
  - Timers are frozen (En=0, Ld=0).
  - Stays while Maint=1; when Maint=0 -> S_RESYNC.
- S_RESYNC lasts exactly one cycle.
  - It drives State=St3 with Ld_NS=Ld_EW=1, so NS loads green and EW loads red.
  - Next state is S_NSG, or S_FLASH if Maint=1.
- Reset in any state, including mid-flash, has priority and returns to S_NSG.
- A Done flag arriving in a phase that does not consume it (e.g. Done_EW in S_NSG) is ignored. Ld for that timer still follows its Done, so that timer reloads and stays consistent.
- Illegal or unreachable state encodings recover to S_NSG on the next edge.

Decomposition:
- Package traf_pkg holds:
  - one-hot St0..St3 constants
  - internal state encodings
  - lamp encodings RED=100, YEL=010, GRN=001, OFF=000
  - timer load constants (green_NS=8'h36, yellow_NS=8'h04, red_NS=8'h3b, plus the EW set)
- The prescaler is a natural sub-module, tick_gen (params TICK_DIV/TICK_W; ports Clk, Reset, Tick).

Test Plan:
Use TICK_DIV=4 throughout.
1. Reset 3 cycles, release -> State=0001, NS=001, EW=100. En_NS/En_EW pulse on cycles 4, 8, 12… after release; no Ld.
2. Stub timers: raise Done_NS on the tick cycle in S_NSG -> Ld_NS=1 that cycle. Next cycle State=0010, NS=010, EW=100. Repeat through S_EWG and S_EWY back to 0001.
3. Integration with the real NS timer plus a mirrored EW model -> S_NSG lasts 55 ticks (220 cycles) and S_NSY 5 ticks. The full cycle returns to State=0001 with Q_NS reloaded to 8'h36.
4. Maint=1 in the same cycle as Done_NS in S_NSG -> no Ld_NS. Next State=0000, both lamps 000, then 010/000 alternating each tick; En_NS stays 0.
5. Maint 1->0 -> exactly one cycle with State=1000, Ld_NS=Ld_EW=1, lamps 100/100. Then State=0001 with Q_NS=8'h36.
6. Reset asserted mid-flash and in S_EWY -> next cycle State=0001, NS=001, EW=100, and the prescaler restarts (next tick 4 cycles after release).
